// File: rtl/block_mac3x3_pkg.sv
// ---------------------------------------------------------------------------
// block_mac3x3_pkg
// Shared definitions for the 3x3 block multiply-accumulate unit:
//   BLK_DIM / BLK_ELEMS  - block geometry (3x3, 9 elements)
//   mac_state_t          - accumulation FSM state (IDLE, ACCUM)
//   elem_idx()           - row-major element index used for all block packing
// ---------------------------------------------------------------------------
package block_mac3x3_pkg;

    localparam int BLK_DIM   = 3;
    localparam int BLK_ELEMS = BLK_DIM * BLK_DIM;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } mac_state_t;

    // Element (row, col) lives at slot row*3+col of a packed block.
    function automatic int elem_idx(input int row, input int col);
        return row * BLK_DIM + col;
    endfunction

endpackage

// File: rtl/block_mac3x3_dot3.sv
// ---------------------------------------------------------------------------
// block_mac3x3_dot3
// Combinational unsigned 3-term dot product, zero-extended to ACC_WIDTH.
// Ports:
//   a_i   [3*DATA_WIDTH-1:0]  three A operands, term k at [k*DATA_WIDTH +: DATA_WIDTH]
//   b_i   [3*DATA_WIDTH-1:0]  three B operands, same packing
//   dot_o [ACC_WIDTH-1:0]     sum over k of a_i[k]*b_i[k]
// ACC_WIDTH must be at least 2*DATA_WIDTH+2 so the 3-term sum never wraps.
// ---------------------------------------------------------------------------
module block_mac3x3_dot3
    import block_mac3x3_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int ACC_WIDTH  = 16
) (
    input  logic [BLK_DIM*DATA_WIDTH-1:0] a_i,
    input  logic [BLK_DIM*DATA_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0]          dot_o
);

    logic [2*DATA_WIDTH-1:0] prod [BLK_DIM];

    generate
        for (genvar gi = 0; gi < BLK_DIM; gi++) begin : g_prod
            // Operands widened first so the multiply is evaluated at full product width.
            assign prod[gi] = {{DATA_WIDTH{1'b0}}, a_i[gi*DATA_WIDTH +: DATA_WIDTH]}
                            * {{DATA_WIDTH{1'b0}}, b_i[gi*DATA_WIDTH +: DATA_WIDTH]};
        end
    endgenerate

    always_comb begin
        dot_o = '0;
        for (int k = 0; k < BLK_DIM; k++) begin
            dot_o = dot_o + {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, prod[k]};
        end
    end

endmodule

// File: rtl/block_mac3x3.sv
// ---------------------------------------------------------------------------
// block_mac3x3
// Streaming 3x3 block multiply-accumulate: C += A x B per accepted beat,
// accumulated over a group delimited by in_first / in_last, one result block
// per group held in a single output register.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     operand beat handshake
//   in_first/in_last      group delimiters carried with the beat
//   a_blk, b_blk          9*DATA_WIDTH row-major operand blocks
//   out_valid/out_ready   result handshake
//   c_blk                 9*ACC_WIDTH row-major result block
//   proto_err             sticky protocol-violation flag
// Build option: define BLOCK_MAC_SATURATE_EN to clamp each element at
// 2^ACC_WIDTH-1 instead of wrapping during accumulation.
// ---------------------------------------------------------------------------
module block_mac3x3
    import block_mac3x3_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_first,
    input  logic                            in_last,
    input  logic [BLK_ELEMS*DATA_WIDTH-1:0] a_blk,
    input  logic [BLK_ELEMS*DATA_WIDTH-1:0] b_blk,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BLK_ELEMS*ACC_WIDTH-1:0]  c_blk,
    output logic                            proto_err
);

    mac_state_t                       state_q;
    logic [BLK_ELEMS*ACC_WIDTH-1:0]   acc_q;
    logic [BLK_ELEMS*ACC_WIDTH-1:0]   c_q;
    logic                             out_valid_q;
    logic                             proto_err_q;

    logic [BLK_ELEMS*ACC_WIDTH-1:0]   term;
    logic [BLK_ELEMS*ACC_WIDTH-1:0]   sum_d;
    logic                             beat;
    logic                             restart;

    // The output register can take a new result in the same cycle it drains.
    assign in_ready = !out_valid_q || out_ready;
    assign beat     = in_valid && in_ready;
    // A beat in IDLE always opens a group; in_first inside a group reopens it.
    assign restart  = (state_q == IDLE) || in_first;

    generate
        for (genvar gi = 0; gi < BLK_ELEMS; gi++) begin : g_elem
            localparam int ROW = gi / BLK_DIM;
            localparam int COL = gi % BLK_DIM;

            logic [BLK_DIM*DATA_WIDTH-1:0] a_row;
            logic [BLK_DIM*DATA_WIDTH-1:0] b_col;
            logic [ACC_WIDTH-1:0]          acc_next;

            for (genvar gk = 0; gk < BLK_DIM; gk++) begin : g_k
                assign a_row[gk*DATA_WIDTH +: DATA_WIDTH] = a_blk[elem_idx(ROW, gk)*DATA_WIDTH +: DATA_WIDTH];
                assign b_col[gk*DATA_WIDTH +: DATA_WIDTH] = b_blk[elem_idx(gk, COL)*DATA_WIDTH +: DATA_WIDTH];
            end

            block_mac3x3_dot3 #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_dot3 (
                .a_i   (a_row),
                .b_i   (b_col),
                .dot_o (term[gi*ACC_WIDTH +: ACC_WIDTH])
            );

`ifdef BLOCK_MAC_SATURATE_EN
            // One extra bit catches the carry; a saturated element stays at
            // the ceiling because terms are never negative.
            logic [ACC_WIDTH:0] wide_sum;
            assign wide_sum = {1'b0, acc_q[gi*ACC_WIDTH +: ACC_WIDTH]}
                            + {1'b0, term[gi*ACC_WIDTH +: ACC_WIDTH]};
            assign acc_next = wide_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : wide_sum[ACC_WIDTH-1:0];
`else
            assign acc_next = acc_q[gi*ACC_WIDTH +: ACC_WIDTH] + term[gi*ACC_WIDTH +: ACC_WIDTH];
`endif

            assign sum_d[gi*ACC_WIDTH +: ACC_WIDTH] = restart ? term[gi*ACC_WIDTH +: ACC_WIDTH] : acc_next;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (beat) begin
                if ((state_q == IDLE && !in_first) || (state_q == ACCUM && in_first)) begin
                    proto_err_q <= 1'b1;
                end
                if (in_last) begin
                    // A new result overrides the drain above when both happen.
                    c_q         <= sum_d;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    state_q     <= IDLE;
                end else begin
                    acc_q       <= sum_d;
                    state_q     <= ACCUM;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign c_blk     = c_q;
    assign proto_err = proto_err_q;

endmodule
